seg7_spi_ctrl: RTL

SEG7_SPI_CTRL -- requirements
Module: seg7_spi_ctrl

---
 rtl/seg7_spi_ctrl_pkg.sv | 27 ++
 rtl/seg7_spi_ctrl_bcd4_inc.sv | 25 ++
 rtl/seg7_spi_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_spi_ctrl_pkg.sv
// Shared definitions for the 7-segment SPI controller.
//   - Command opcodes (upper nibble of the command byte)
//   - Colon/decimal-point encodings driven on o_colon
//   - Frame FSM state encoding
package seg7_spi_ctrl_pkg;

    localparam logic [3:0] OP_WRDIG   = 4'h1;  // 2-byte: write one BCD digit
    localparam logic [3:0] OP_WRCOLON = 4'h2;  // 2-byte: write colon mode
    localparam logic [3:0] OP_RDDIG   = 4'h3;  // 1-byte: read one BCD digit
    localparam logic [3:0] OP_AUTO    = 4'h4;  // 1-byte: auto-increment enable

    localparam logic [1:0] COLON_ON   = 2'b00;
    localparam logic [1:0] COLON_DP   = 2'b01;
    localparam logic [1:0] COLON_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_COMMIT    = 2'd2
    } state_t;

    // The unused code 2'b10 is folded onto "none".
    function automatic logic [1:0] colon_norm(input logic [1:0] v);
        return (v == 2'b10) ? COLON_NONE : v;
    endfunction

endpackage

// File: rtl/seg7_spi_ctrl_bcd4_inc.sv
// bcd4_inc: combinational 4-digit BCD incrementer, 9999 wraps to 0000.
//   i_val [15:0]  four BCD digits, [3:0] is the least significant
//   o_val [15:0]  i_val + 1 in BCD
module bcd4_inc (
    input  logic [15:0] i_val,
    output logic [15:0] o_val
);

    always_comb begin
        logic w_carry;
        w_carry = 1'b1;
        o_val   = i_val;
        for (int k = 0; k < 4; k++) begin
            if (w_carry) begin
                if (i_val[k*4 +: 4] >= 4'd9) begin
                    o_val[k*4 +: 4] = 4'd0;   // carry ripples onward
                end else begin
                    o_val[k*4 +: 4] = i_val[k*4 +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/seg7_spi_ctrl.sv
// seg7_spi_ctrl: SPI byte-command front end for a 4-digit BCD display.
//   i_wf_clk            sole clock, rising edge
//   i_reset             synchronous active-high reset
//   i_rx_valid/i_rx_data  received SPI byte strobe / byte
//   i_tick              one-second auto-increment pulse
//   o_tx_valid/o_tx_data  response strobe / byte (byte held between strobes)
//   o_digit0..o_digit3  BCD digits, o_digit0 is the LSD
//   o_colon             00 colon, 01 decimal point, 11 none
//   o_auto_en           auto-increment enable
//   o_frame_err         one-cycle pulse on timeout or rejected command
module seg7_spi_ctrl
    import seg7_spi_ctrl_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 31916,
    parameter logic [7:0] ACK_BYTE    = 8'hA5,
    parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
    input  logic       i_wf_clk,
    input  logic       i_reset,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    input  logic       i_tick,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    output logic [3:0] o_digit0,
    output logic [3:0] o_digit1,
    output logic [3:0] o_digit2,
    output logic [3:0] o_digit3,
    output logic [1:0] o_colon,
    output logic       o_auto_en,
    output logic       o_frame_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_cmd_wrdig, w_cmd_wrdig_nxt;
    logic [1:0]       r_cmd_addr, w_cmd_addr_nxt;
    logic [15:0]      r_digits, w_digits_nxt, w_digits_inc;
    logic [1:0]       r_colon;
    logic             r_auto_en, r_pend, w_pend_nxt;
    logic             r_tx_valid, r_frame_err;
    logic [7:0]       r_tx_data;

    logic       w_tx_fire, w_ferr, w_dig_wr, w_colon_wr, w_auto_wr, w_inc;
    logic [7:0] w_tx_byte;
    logic [3:0] w_op, w_addr;
    logic       w_addr_ok;

    assign w_op      = i_rx_data[7:4];
    assign w_addr    = i_rx_data[3:0];
    assign w_addr_ok = (w_addr[3:2] == 2'b00);

    bcd4_inc u_inc (.i_val(r_digits), .o_val(w_digits_inc));

    // Frame FSM. Register writes happen on the edge that accepts the data
    // byte, so they are visible together with tx_valid one cycle later;
    // the COMMIT cycle that follows only swallows any extra rx byte.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cmd_wrdig_nxt = r_cmd_wrdig;
        w_cmd_addr_nxt  = r_cmd_addr;
        w_tx_fire       = 1'b0;
        w_tx_byte       = ERR_BYTE;
        w_ferr          = 1'b0;
        w_dig_wr        = 1'b0;
        w_colon_wr      = 1'b0;
        w_auto_wr       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    // Reject by default; valid opcodes override below.
                    w_tx_fire = 1'b1;
                    w_ferr    = 1'b1;
                    case (w_op)
                        OP_WRDIG: if (w_addr_ok) begin
                            w_tx_fire       = 1'b0;
                            w_ferr          = 1'b0;
                            w_state_nxt     = ST_WAIT_DATA;
                            w_cnt_nxt       = '0;
                            w_cmd_wrdig_nxt = 1'b1;
                            w_cmd_addr_nxt  = w_addr[1:0];
                        end
                        OP_WRCOLON: begin
                            w_tx_fire       = 1'b0;
                            w_ferr          = 1'b0;
                            w_state_nxt     = ST_WAIT_DATA;
                            w_cnt_nxt       = '0;
                            w_cmd_wrdig_nxt = 1'b0;
                        end
                        OP_RDDIG: if (w_addr_ok) begin
                            w_ferr    = 1'b0;
                            w_tx_byte = {4'h0, r_digits[{w_addr[1:0], 2'b00} +: 4]};
                        end
                        OP_AUTO: begin
                            w_ferr    = 1'b0;
                            w_tx_byte = ACK_BYTE;
                            w_auto_wr = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT_DATA: begin
                if (i_rx_valid) begin
                    // A byte on the final counted cycle still beats the timeout.
                    w_state_nxt = ST_COMMIT;
                    w_tx_fire   = 1'b1;
                    if (!r_cmd_wrdig) begin
                        w_colon_wr = 1'b1;
                        w_tx_byte  = ACK_BYTE;
                    end else if (i_rx_data[3:0] <= 4'd9) begin
                        w_dig_wr   = 1'b1;
                        w_tx_byte  = ACK_BYTE;
                    end else begin
                        w_ferr     = 1'b1;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_tx_fire   = 1'b1;
                    w_ferr      = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Tick arbitration: an SPI digit write wins; a tick (or an already
    // pending one) that collides with it is held for exactly one slot.
    always_comb begin
        w_inc        = r_auto_en & ~w_dig_wr & (i_tick | r_pend);
        w_pend_nxt   = r_auto_en &  w_dig_wr & (i_tick | r_pend);
        w_digits_nxt = r_digits;
        if (w_dig_wr)
            w_digits_nxt[{r_cmd_addr, 2'b00} +: 4] = i_rx_data[3:0];
        else if (w_inc)
            w_digits_nxt = w_digits_inc;
    end

    always_ff @(posedge i_wf_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cmd_wrdig <= 1'b0;
            r_cmd_addr  <= 2'b00;
            r_digits    <= '0;
            r_colon     <= COLON_NONE;
            r_auto_en   <= 1'b0;
            r_pend      <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_wrdig <= w_cmd_wrdig_nxt;
            r_cmd_addr  <= w_cmd_addr_nxt;
            r_digits    <= w_digits_nxt;
            r_pend      <= w_pend_nxt;
            r_tx_valid  <= w_tx_fire;
            r_frame_err <= w_ferr;
            if (w_tx_fire)  r_tx_data <= w_tx_byte;
            if (w_colon_wr) r_colon   <= colon_norm(i_rx_data[1:0]);
            if (w_auto_wr)  r_auto_en <= i_rx_data[0];
        end
    end

    assign o_tx_valid  = r_tx_valid;
    assign o_tx_data   = r_tx_data;
    assign o_digit0    = r_digits[3:0];
    assign o_digit1    = r_digits[7:4];
    assign o_digit2    = r_digits[11:8];
    assign o_digit3    = r_digits[15:12];
    assign o_colon     = r_colon;
    assign o_auto_en   = r_auto_en;
    assign o_frame_err = r_frame_err;

endmodule
